multi_edge_detector: RTL and testbench

MULTI_EDGE_DETECTOR -- requirements
Module: multi_edge_detector

---
 rtl/multi_edge_detector.sv | 143 ++++++++++++++
 tb/tb_multi_edge_detector.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_edge_detector.sv
// Multi-channel edge detector: synchroniser, debounce filter, edge
// classification, stretched detection pulse and sticky event flag per channel.
//
//   state    | meaning
//   ---------+---------------------------------------------------------------
//   ST_INIT  | baseline unknown; filtered level follows the synchroniser
//   ST_ARMED | baseline known; accepted level changes may raise events
module multi_edge_detector #(
    parameter int CHANNELS    = 4,
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 1,
    parameter int PULSE_EXT   = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [CHANNELS-1:0]     signal_in,
    input  logic [2*CHANNELS-1:0]   edge_mode,
    input  logic [CHANNELS-1:0]     sticky_clr,
    output logic [CHANNELS-1:0]     pulse_out,
    output logic [CHANNELS-1:0]     edge_level,
    output logic [CHANNELS-1:0]     event_sticky,
    output logic                    irq
);

    localparam int               CNT_W      = $clog2(FILTER_LEN) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(FILTER_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [7:0]       PULSE_LOAD = 8'(PULSE_EXT);
    // INIT lasts until the reset zeros have left the synchroniser, so the
    // baseline is a real sample and a level present at reset raises no event.
    localparam logic [2:0]       FILL_LAST  = 3'(SYNC_STAGES);

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_ARMED = 1'b1
    } state_t;

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
            logic [SYNC_STAGES-1:0] r_sync;
            state_t                 r_state;
            logic [2:0]             r_fill;
            logic                   r_level;
            logic [CNT_W-1:0]       r_cnt;
            logic [7:0]             r_pcnt;
            logic                   r_sticky;
            logic                   w_sync;
            logic [1:0]             w_mode;
            logic                   w_accept;
            logic                   w_event;

            assign w_sync   = r_sync[SYNC_STAGES-1];
            assign w_mode   = edge_mode[2*gi +: 2];
            assign w_accept = (r_state == ST_ARMED) && (w_sync != r_level) &&
                              (r_cnt == CNT_LAST);

            // Classify an accepted change against the channel's edge mode
            always_comb begin
                w_event = 1'b0;
                if (w_accept) begin
                    case (w_mode)
                        2'b00:   w_event = ~w_sync;
                        2'b01:   w_event = w_sync;
                        2'b10:   w_event = 1'b1;
                        default: w_event = 1'b0;
                    endcase
                end
            end

            // Input synchroniser chain
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_sync <= '0;
                end else begin
                    r_sync <= {r_sync[SYNC_STAGES-2:0], signal_in[gi]};
                end
            end

            // Baseline capture and debounce of the filtered level
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_state <= ST_INIT;
                    r_fill  <= 3'd0;
                    r_level <= 1'b0;
                    r_cnt   <= '0;
                end else begin
                    case (r_state)
                        ST_INIT: begin
                            r_level <= w_sync;
                            r_cnt   <= '0;
                            if (r_fill == FILL_LAST) begin
                                r_state <= ST_ARMED;
                            end else begin
                                r_fill <= r_fill + 3'd1;
                            end
                        end
                        ST_ARMED: begin
                            if (w_sync == r_level) begin
                                r_cnt <= '0;
                            end else if (r_cnt == CNT_LAST) begin
                                r_level <= w_sync;
                                r_cnt   <= '0;
                            end else begin
                                r_cnt <= r_cnt + CNT_ONE;
                            end
                        end
                        default: r_state <= ST_INIT;
                    endcase
                end
            end

            // Pulse stretcher; a new event reloads so retriggers never gap
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_pcnt <= 8'd0;
                end else if (w_event) begin
                    r_pcnt <= PULSE_LOAD;
                end else if (r_pcnt != 8'd0) begin
                    r_pcnt <= r_pcnt - 8'd1;
                end
            end

            // Sticky event flag; a set wins over a same-cycle clear
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_sticky <= 1'b0;
                end else if (w_event) begin
                    r_sticky <= 1'b1;
                end else if (sticky_clr[gi]) begin
                    r_sticky <= 1'b0;
                end
            end

            assign pulse_out[gi]    = (r_pcnt != 8'd0);
            assign edge_level[gi]   = r_level;
            assign event_sticky[gi] = r_sticky;
        end
    endgenerate

    assign irq = |event_sticky;

endmodule

// File: tb/tb_multi_edge_detector.sv
// Bench for multi_edge_detector: three parameterisations driven side by side,
// directed scenarios followed by random traffic, all outputs compared every
// cycle against a history-based reference model.
module tb_multi_edge_detector;

    localparam int NI   = 3;
    localparam int HMAX = 2048;

    int p_sync  [NI] = '{2, 3, 2};
    int p_filt  [NI] = '{1, 4, 1};
    int p_pulse [NI] = '{1, 5, 5};

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [3:0] sin  [NI];
    logic [7:0] mode [NI];
    logic [3:0] clr  [NI];
    logic [3:0] pout [NI];
    logic [3:0] lvl  [NI];
    logic [3:0] stk  [NI];
    logic       irq  [NI];

    multi_edge_detector #(.CHANNELS(4), .SYNC_STAGES(2), .FILTER_LEN(1), .PULSE_EXT(1)) u_a (
        .clk(clk), .rst(rst), .signal_in(sin[0]), .edge_mode(mode[0]), .sticky_clr(clr[0]),
        .pulse_out(pout[0]), .edge_level(lvl[0]), .event_sticky(stk[0]), .irq(irq[0]));
    multi_edge_detector #(.CHANNELS(4), .SYNC_STAGES(3), .FILTER_LEN(4), .PULSE_EXT(5)) u_b (
        .clk(clk), .rst(rst), .signal_in(sin[1]), .edge_mode(mode[1]), .sticky_clr(clr[1]),
        .pulse_out(pout[1]), .edge_level(lvl[1]), .event_sticky(stk[1]), .irq(irq[1]));
    multi_edge_detector #(.CHANNELS(4), .SYNC_STAGES(2), .FILTER_LEN(1), .PULSE_EXT(5)) u_c (
        .clk(clk), .rst(rst), .signal_in(sin[2]), .edge_mode(mode[2]), .sticky_clr(clr[2]),
        .pulse_out(pout[2]), .edge_level(lvl[2]), .event_sticky(stk[2]), .irq(irq[2]));

    // Reference model: raw samples per edge since reset release, plus the
    // filtered level, edge index of the latest event and the sticky flag.
    bit hist    [NI][4][HMAX];
    int n;
    bit f_m     [NI][4];
    int last_ev [NI][4];
    bit stk_m   [NI][4];

    int checks   = 0;
    int failures = 0;
    int cnt;
    logic seen;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Synchronised value seen by edge m: the sample taken SYNC edges earlier,
    // or the reset zero if that lies before the first edge.
    function automatic bit s_at(int k, int c, int m);
        return (m - p_sync[k] >= 1) ? hist[k][c][m - p_sync[k]] : 1'b0;
    endfunction

    task automatic model_edge();
        n++;
        for (int k = 0; k < NI; k++) begin
            for (int c = 0; c < 4; c++) begin
                hist[k][c][n] = sin[k][c];
            end
        end
        for (int k = 0; k < NI; k++) begin
            for (int c = 0; c < 4; c++) begin
                bit ev;
                bit acc;
                bit [1:0] md;
                ev = 1'b0;
                md = mode[k][2*c +: 2];
                if (n <= p_sync[k] + 1) begin
                    f_m[k][c] = s_at(k, c, n);
                end else begin
                    // Accept when the last FILTER synchronised values, all seen
                    // while armed, differ from the current filtered level.
                    acc = (n - p_filt[k] + 1 >= p_sync[k] + 2);
                    if (acc) begin
                        for (int j = n - p_filt[k] + 1; j <= n; j++) begin
                            if (s_at(k, c, j) == f_m[k][c]) acc = 1'b0;
                        end
                    end
                    if (acc) begin
                        f_m[k][c] = ~f_m[k][c];
                        ev = (md == 2'b10) || (md == 2'b01 && f_m[k][c]) ||
                             (md == 2'b00 && !f_m[k][c]);
                    end
                end
                if (ev) last_ev[k][c] = n;
                if (ev) stk_m[k][c] = 1'b1;
                else if (clr[k][c]) stk_m[k][c] = 1'b0;
            end
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < NI; k++) begin
            logic [3:0] ep, el, es;
            for (int c = 0; c < 4; c++) begin
                ep[c] = (n - last_ev[k][c]) < p_pulse[k];
                el[c] = f_m[k][c];
                es[c] = stk_m[k][c];
            end
            chk($sformatf("pulse_out[u%0d] n=%0d", k, n), 32'(pout[k]), 32'(ep));
            chk($sformatf("edge_level[u%0d] n=%0d", k, n), 32'(lvl[k]), 32'(el));
            chk($sformatf("event_sticky[u%0d] n=%0d", k, n), 32'(stk[k]), 32'(es));
            chk($sformatf("irq[u%0d] n=%0d", k, n), 32'(irq[k]), 32'(|es));
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        model_edge();
        check_all();
    endtask

    // Assert reset asynchronously, confirm outputs clear without a clock edge,
    // then release on a falling edge and restart the model.
    task automatic do_reset();
        rst = 1'b1;
        #1;
        for (int k = 0; k < NI; k++) begin
            chk($sformatf("rst_pulse_out[u%0d]", k), 32'(pout[k]), 32'd0);
            chk($sformatf("rst_edge_level[u%0d]", k), 32'(lvl[k]), 32'd0);
            chk($sformatf("rst_event_sticky[u%0d]", k), 32'(stk[k]), 32'd0);
            chk($sformatf("rst_irq[u%0d]", k), 32'(irq[k]), 32'd0);
        end
        n = 0;
        for (int k = 0; k < NI; k++) begin
            for (int c = 0; c < 4; c++) begin
                f_m[k][c]     = 1'b0;
                last_ev[k][c] = -1000;
                stk_m[k][c]   = 1'b0;
            end
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        for (int k = 0; k < NI; k++) begin
            sin[k]  = 4'h0;
            clr[k]  = 4'h0;
            mode[k] = 8'hAA;
        end
        // u_a: ch0 rising, ch1 rising, ch2 disabled, ch3 both
        mode[0] = 8'b10_11_01_01;
        sin[0][1] = 1'b1;
        #1;
        do_reset();
        repeat (6) step();
        chk("a_no_event_from_reset_level", 32'(stk[0][1]), 32'd0);

        // Rising edge on u_a ch0: pulse exactly after the third edge
        sin[0][0] = 1'b1;
        step();
        step();
        chk("a_ch0_pulse_before_E2", 32'(pout[0][0]), 32'd0);
        step();
        chk("a_ch0_pulse_at_E2", 32'(pout[0][0]), 32'd1);
        chk("a_ch0_sticky", 32'(stk[0][0]), 32'd1);
        chk("a_irq_set", 32'(irq[0]), 32'd1);
        step();
        chk("a_ch0_pulse_after_E2", 32'(pout[0][0]), 32'd0);

        // u_a ch1 falls then rises again: one rising event only
        sin[0][1] = 1'b0;
        repeat (3) step();
        sin[0][1] = 1'b1;
        cnt = 0;
        repeat (8) begin
            step();
            cnt += int'(pout[0][1]);
        end
        chk("a_ch1_single_pulse", 32'(cnt), 32'd1);

        // u_a ch2 disabled: level tracks, no pulses
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            sin[0][2] = ((i % 4) < 2);
            step();
            cnt += int'(pout[0][2]);
        end
        chk("a_ch2_disabled_pulses", 32'(cnt), 32'd0);

        // u_a ch3 event coincides with a clear strobe: flag stays set
        sin[0][3] = 1'b1;
        step();
        step();
        clr[0] = 4'b1000;
        step();
        clr[0] = 4'h0;
        chk("a_ch3_set_beats_clr", 32'(stk[0][3]), 32'd1);
        step();
        clr[0] = 4'hF;
        step();
        clr[0] = 4'h0;
        chk("a_sticky_cleared", 32'(stk[0]), 32'd0);
        chk("a_irq_cleared", 32'(irq[0]), 32'd0);

        // u_b ch0 (filter 4): a 3-cycle glitch is rejected
        sin[1][0] = 1'b1;
        repeat (3) step();
        sin[1][0] = 1'b0;
        cnt = 0;
        repeat (12) begin
            step();
            cnt += int'(pout[1][0]);
        end
        chk("b_glitch_pulses", 32'(cnt), 32'd0);
        chk("b_glitch_level", 32'(lvl[1][0]), 32'd0);

        // 4-cycle high then low: rising accepted 6 edges after first high
        // sample, falling 4 edges later reloads the 5-cycle pulse, so the
        // output is high 4 + 5 = 9 cycles in total.
        cnt = 0;
        sin[1][0] = 1'b1;
        repeat (4) begin
            step();
            cnt += int'(pout[1][0]);
        end
        sin[1][0] = 1'b0;
        repeat (3) begin
            step();
            cnt += int'(pout[1][0]);
        end
        chk("b_level_high", 32'(lvl[1][0]), 32'd1);
        repeat (13) begin
            step();
            cnt += int'(pout[1][0]);
        end
        chk("b_two_events_high_cycles", 32'(cnt), 32'd9);
        chk("b_level_low_again", 32'(lvl[1][0]), 32'd0);

        // u_c ch0 (pulse 5): edges 3 cycles apart give 3 + 5 = 8 high cycles
        cnt = 0;
        sin[2][0] = 1'b1;
        repeat (3) begin
            step();
            cnt += int'(pout[2][0]);
        end
        sin[2][0] = 1'b0;
        repeat (12) begin
            step();
            cnt += int'(pout[2][0]);
        end
        chk("c_retrigger_high_cycles", 32'(cnt), 32'd8);

        // u_b ch1: reset in the middle of a 5-cycle pulse
        sin[1][1] = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            step();
            seen = pout[1][1];
        end
        chk("b_ch1_pulse_seen", 32'(seen), 32'd1);
        step();
        chk("b_ch1_pulse_mid", 32'(pout[1][1]), 32'd1);
        #2;
        do_reset();

        // Random traffic with mode changes, clear strobes and one reset
        for (int i = 0; i < 900; i++) begin
            if (i % 60 == 0) begin
                for (int k = 0; k < NI; k++) mode[k] = 8'($urandom);
            end
            for (int k = 0; k < NI; k++) begin
                for (int c = 0; c < 4; c++) begin
                    if ($urandom_range((k == 1) ? 5 : 3) == 0) sin[k][c] = ~sin[k][c];
                end
                clr[k] = 4'($urandom & $urandom & $urandom);
            end
            if (i == 450) do_reset();
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
